// File: rtl/shift_serializer_pkg.sv
// Shared types for the parallel-to-serial shifter.
package shift_serializer_pkg;

  // Transmitter state: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out shifter. Words go out MSB first, one bit per
// un-paused cycle. A new word can be taken in the last-bit cycle of the
// current one, so a held valid gives a gap-free bit stream.
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [w-1:0] d,
  input  logic         valid,
  output logic         ready,
  input  logic         pause,
  output logic         sout,
  output logic         shl_o,
  output logic         done
);

  localparam int            CW       = $clog2(w);
  localparam logic [CW-1:0] CNT_LAST = CW'(w - 1);

  state_t        state;
  logic [w-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          accept;

  // Outputs decode straight from the current state and the live pause/valid.
  always_comb begin
    shl_o  = (state == SHIFT) && !pause;
    sout   = shl_o ? sreg[w-1] : 1'b0;
    done   = shl_o && (cnt == '0);
    ready  = (state == IDLE) || done;
    accept = valid && ready;
  end

  // Shift register, bit counter and state; clear beats load, load beats shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (clr) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= d;
      cnt   <= CNT_LAST;
    end else if (done) begin
      state <= IDLE;
      sreg  <= '0;
    end else if (shl_o) begin
      sreg  <= {sreg[w-2:0], 1'b0};
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer (w=8): directed scenarios plus a randomized
// loopback against a word-level reference model.
module tb_shift_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] d;
  logic       valid;
  logic       ready;
  logic       pause;
  logic       sout;
  logic       shl_o;
  logic       done;

  int tests = 0;
  int fails = 0;

  shift_serializer #(.w(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .d     (d),
    .valid (valid),
    .ready (ready),
    .pause (pause),
    .sout  (sout),
    .shl_o (shl_o),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; valid = 1'b0; pause = 1'b0; d = 8'h00;
    step();
    step();
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests++; if (sout  !== 1'b0) begin fails++; $display("FAIL reset_sout got=%b exp=0", sout); end
    tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL reset_shl got=%b exp=0", shl_o); end
    tests++; if (done  !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [7:0] word = 8'hA5;
    valid = 1'b1; d = word;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL single_accept_ready got=%b exp=1", ready); end
    step();
    valid = 1'b0; d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++; if (shl_o !== 1'b1) begin fails++; $display("FAIL single_shl bit%0d got=%b exp=1", i, shl_o); end
      tests++; if (sout !== word[7-i]) begin fails++; $display("FAIL single_sout bit%0d got=%b exp=%b", i, sout, word[7-i]); end
      tests++; if (done !== (i == 7)) begin fails++; $display("FAIL single_done bit%0d got=%b exp=%b", i, done, (i == 7)); end
      tests++; if (ready !== (i == 7)) begin fails++; $display("FAIL single_ready bit%0d got=%b exp=%b", i, ready, (i == 7)); end
      step();
    end
    @(negedge clk);
    tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL single_idle_shl got=%b exp=0", shl_o); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL single_idle_ready got=%b exp=1", ready); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream = 16'hA53C;
    valid = 1'b1; d = 8'hA5;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_pre_ready got=%b exp=1", ready); end
    step();
    d = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests++; if (shl_o !== 1'b1) begin fails++; $display("FAIL b2b_shl bit%0d got=%b exp=1", i, shl_o); end
      tests++; if (sout !== stream[15-i]) begin fails++; $display("FAIL b2b_sout bit%0d got=%b exp=%b", i, sout, stream[15-i]); end
      tests++; if (done !== (i == 7 || i == 15)) begin fails++; $display("FAIL b2b_done bit%0d got=%b exp=%b", i, done, (i == 7 || i == 15)); end
      tests++; if (ready !== (i == 7 || i == 15)) begin fails++; $display("FAIL b2b_ready bit%0d got=%b exp=%b", i, ready, (i == 7 || i == 15)); end
      step();
      if (i == 7) begin valid = 1'b0; d = 8'hFF; end
    end
    @(negedge clk);
    tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL b2b_post_shl got=%b exp=0", shl_o); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_post_ready got=%b exp=1", ready); end
    step();
  endtask

  task automatic test_pause();
    logic [7:0] word = 8'hF0;
    int idx;
    valid = 1'b1; d = word;
    step();
    valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      pause = (c >= 3 && c < 6);
      @(negedge clk);
      if (pause) begin
        tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL pause_shl cyc%0d got=%b exp=0", c, shl_o); end
        tests++; if (sout !== 1'b0) begin fails++; $display("FAIL pause_sout cyc%0d got=%b exp=0", c, sout); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL pause_done cyc%0d got=%b exp=0", c, done); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL pause_ready cyc%0d got=%b exp=0", c, ready); end
      end else begin
        idx = (c < 3) ? c : c - 3;
        tests++; if (shl_o !== 1'b1) begin fails++; $display("FAIL pause_run_shl cyc%0d got=%b exp=1", c, shl_o); end
        tests++; if (sout !== word[7-idx]) begin fails++; $display("FAIL pause_run_sout cyc%0d got=%b exp=%b", c, sout, word[7-idx]); end
        tests++; if (done !== (idx == 7)) begin fails++; $display("FAIL pause_run_done cyc%0d got=%b exp=%b", c, done, (idx == 7)); end
      end
      step();
    end
    pause = 1'b0;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL pause_end_ready got=%b exp=1", ready); end
    step();
  endtask

  task automatic test_pause_last();
    logic [7:0] word = 8'h81;
    valid = 1'b1; d = word;
    step();
    valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    // hold the last bit with a competing word offered
    pause = 1'b1; valid = 1'b1; d = 8'h55;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL plast_done cyc%0d got=%b exp=0", c, done); end
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL plast_ready cyc%0d got=%b exp=0", c, ready); end
      step();
    end
    pause = 1'b0; valid = 1'b0;
    @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL plast_release_done got=%b exp=1", done); end
    tests++; if (sout !== 1'b1) begin fails++; $display("FAIL plast_release_sout got=%b exp=1", sout); end
    step();
    @(negedge clk);
    tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL plast_idle_shl got=%b exp=0", shl_o); end
    step();
  endtask

  task automatic test_clr();
    logic [7:0] word2 = 8'h01;
    valid = 1'b1; d = 8'hFF;
    step();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (sout !== 1'b1) begin fails++; $display("FAIL clr_pre_sout bit%0d got=%b exp=1", i, sout); end
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL clr_shl cyc%0d got=%b exp=0", c, shl_o); end
      tests++; if (sout !== 1'b0) begin fails++; $display("FAIL clr_sout cyc%0d got=%b exp=0", c, sout); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL clr_done cyc%0d got=%b exp=0", c, done); end
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL clr_ready cyc%0d got=%b exp=1", c, ready); end
      step();
    end
    valid = 1'b1; d = word2;
    step();
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++; if (shl_o !== 1'b1) begin fails++; $display("FAIL clr_next_shl bit%0d got=%b exp=1", i, shl_o); end
      tests++; if (sout !== word2[7-i]) begin fails++; $display("FAIL clr_next_sout bit%0d got=%b exp=%b", i, sout, word2[7-i]); end
      tests++; if (done !== (i == 7)) begin fails++; $display("FAIL clr_next_done bit%0d got=%b exp=%b", i, done, (i == 7)); end
      step();
    end
  endtask

  task automatic test_async_reset();
    valid = 1'b1; d = 8'hFF;
    step();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #2;
    rst = 1'b1;
    #1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL arst_ready got=%b exp=1", ready); end
    tests++; if (sout  !== 1'b0) begin fails++; $display("FAIL arst_sout got=%b exp=0", sout); end
    tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL arst_shl got=%b exp=0", shl_o); end
    tests++; if (done  !== 1'b0) begin fails++; $display("FAIL arst_done got=%b exp=0", done); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if (shl_o !== 1'b0) begin fails++; $display("FAIL arst_resume_shl cyc%0d got=%b exp=0", c, shl_o); end
      step();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] sentq[$];
    logic [7:0] cur = 8'h00;
    logic [7:0] rx = 8'h00;
    logic [7:0] exp_word;
    logic busy = 1'b0;
    logic e_shl, e_sout, e_done, e_ready, acc;
    int bitn = 0;
    int accepted = 0;
    int received = 0;
    int cyc = 0;
    while (received < 256 && cyc < 20000) begin
      valid = (accepted < 256) && ($urandom_range(3) != 0);
      d     = 8'($urandom);
      pause = ($urandom_range(4) == 0);
      @(negedge clk);
      e_shl   = busy && !pause;
      e_sout  = e_shl ? cur[7-bitn] : 1'b0;
      e_done  = e_shl && (bitn == 7);
      e_ready = !busy || e_done;
      tests++; if (shl_o !== e_shl) begin fails++; $display("FAIL loop_shl cyc%0d got=%b exp=%b", cyc, shl_o, e_shl); end
      tests++; if (sout !== e_sout) begin fails++; $display("FAIL loop_sout cyc%0d got=%b exp=%b", cyc, sout, e_sout); end
      tests++; if (done !== e_done) begin fails++; $display("FAIL loop_done cyc%0d got=%b exp=%b", cyc, done, e_done); end
      tests++; if (ready !== e_ready) begin fails++; $display("FAIL loop_ready cyc%0d got=%b exp=%b", cyc, ready, e_ready); end
      if (shl_o === 1'b1) rx = {rx[6:0], sout};
      if (e_done) begin
        exp_word = sentq.pop_front();
        received++;
        tests++; if (rx !== exp_word) begin fails++; $display("FAIL loop_word n%0d got=%h exp=%h", received, rx, exp_word); end
      end
      acc = valid && e_ready;
      if (acc) begin
        sentq.push_back(d);
        accepted++;
        cur = d; bitn = 0; busy = 1'b1;
      end else if (e_done) begin
        busy = 1'b0;
      end else if (e_shl) begin
        bitn++;
      end
      step();
      cyc++;
    end
    valid = 1'b0; pause = 1'b0;
    tests++; if (received != 256) begin fails++; $display("FAIL loop_timeout got=%0d exp=256", received); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_pause_last();
    test_clr();
    test_async_reset();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 Parameter: w, default 8, word width in bits; legal range w >= 2.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clr  input  1  synchronous clear; aborts any word in flight.
REQ-005 d  input  w  parallel word to transmit.
REQ-006 valid  input  1  d holds a word to transmit.
REQ-007 ready  output  1  block can accept d this cycle.
REQ-008 pause  input  1  stall shifting while high.
REQ-009 sout  output  1  serial data, MSB first.
REQ-010 shl_o  output  1  strobe: sout is a valid bit this cycle.
REQ-011 done  output  1  one-cycle pulse on the last bit of a word.

Function
REQ-012 The block SHALL have states IDLE and SHIFT, a w-bit shift register sreg, and a down-counter cnt of width $clog2(w).
REQ-013 A word SHALL be accepted on a rising edge where valid && ready; d is then loaded into sreg, cnt is loaded with w-1, and the state becomes SHIFT.
REQ-014 ready SHALL equal (state==IDLE) || done.
REQ-015 shl_o SHALL equal (state==SHIFT) && !pause; sout SHALL equal sreg[w-1] whenever shl_o=1 and 0 otherwise.
REQ-016 On each edge with shl_o=1 and cnt!=0, sreg SHALL shift left with 0 entering the LSB and cnt SHALL decrement by 1.
REQ-017 done SHALL equal shl_o && (cnt==0).
REQ-018 On an edge with done=1 and valid=0, the state SHALL become IDLE and sreg SHALL clear to 0.
REQ-019 On an edge with done=1 and valid=1, the next word SHALL load per REQ-013 and the state SHALL stay SHIFT, with no idle cycle between words.
REQ-020 Latency: an unpaused word SHALL occupy exactly w consecutive shl_o cycles, starting the cycle after acceptance.
REQ-021 While pause=1, sreg, cnt and state SHALL hold, and ready SHALL be 0 in SHIFT.
REQ-022 pause=1 during the last-bit cycle SHALL suppress done and acceptance until pause falls.
REQ-023 valid, d and pause SHALL be ignored in SHIFT except as stated in REQ-016 to REQ-022; d SHALL NOT be sampled except on acceptance.
REQ-024 clr=1 on an edge SHALL force IDLE, sreg=0 and cnt=0; clr takes priority over acceptance, shifting and pause.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force IDLE, sreg=0 and cnt=0.
REQ-026 Output values during and after rst: ready=1, sout=0, shl_o=0, done=0.
REQ-027 A word in flight when rst or clr asserts SHALL be discarded; transmission SHALL NOT resume afterwards.

Structure
REQ-028 The state enum type SHALL live in the shared package; w and the counter width SHALL stay local to the module.
REQ-029 There SHALL be no sub-module; sreg, cnt and the FSM are implemented in a single always_ff with asynchronous rst, plus combinational output assigns.

Verification
REQ-030 w=8, accept 8'hA5 with pause=0 -> sout=1,0,1,0,0,1,0,1 on 8 consecutive shl_o cycles; done only on the 8th; ready returns to 1.
REQ-031 Back-to-back: A5 then 3C, with valid held -> 16 consecutive shl_o cycles; bit stream A5 then 3C; two done pulses, 8 cycles apart; ready=1 only in the two done cycles and the idle cycles before and after.
REQ-032 pause=1 for 3 cycles after bit 3 of 8'hF0 -> shl_o=0 for those 3 cycles; stream still 11110000; done delayed by exactly 3 cycles.
REQ-033 clr after bit 4 of 8'hFF -> next cycle IDLE, sout=0, shl_o=0, no done; a following 8'h01 transmits correctly.
REQ-034 rst asserted mid-clock-period during a word -> outputs reach reset values before the next edge.
REQ-035 Loopback: connect shl_o/sout to an 8-bit shift-left receiver register, send 256 random words -> each captured word equals the sent word.
